// File: rtl/heater_ctrl.sv
// Soft-start heater controller: ramps PWM duty toward a goal, holds the heater's
// error-clear through pipeline fill, and latches FAULT once enough errors are counted.
module heater_ctrl #(
    parameter int PWM_BITS      = 8,
    parameter int RAMP_DIV      = 256,
    parameter int SETTLE_CYCLES = 2500,
    parameter int ERR_LIMIT     = 4,
    parameter int CNT_BITS      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [PWM_BITS-1:0] target_duty,
    input  logic                clear,
    input  logic                heater_error,
    output logic                heater_enable,
    output logic                heater_err_clear,
    output logic [PWM_BITS-1:0] duty_now,
    output logic [2:0]          state,
    output logic [CNT_BITS-1:0] err_count,
    output logic                fault
);

    localparam int STEP_BITS   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int SETTLE_BITS = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RAMP_UP   = 3'd1;
    localparam logic [2:0] S_HOLD      = 3'd2;
    localparam logic [2:0] S_RAMP_DOWN = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic [PWM_BITS-1:0]    pwm_cnt;
    logic [PWM_BITS-1:0]    goal;
    logic [PWM_BITS-1:0]    duty_next;
    logic [STEP_BITS-1:0]   step_cnt;
    logic [SETTLE_BITS-1:0] settle_cnt;
    logic [SETTLE_BITS-1:0] settle_next;
    logic [2:0]             state_next;
    logic                   err_prev;
    logic                   active;
    logic                   step_wrap;
    logic                   count_event;
    logic                   limit_hit;
    logic                   err_clear_next;

    assign active      = (state == S_RAMP_UP) || (state == S_HOLD) || (state == S_RAMP_DOWN);
    assign goal        = run ? target_duty : '0;
    assign step_wrap   = active && (step_cnt == STEP_BITS'(RAMP_DIV - 1));
    // Only edges seen while the heater flag is armed count; clear beats a coincident edge.
    assign count_event = heater_error && !err_prev && !heater_err_clear && !clear;
    assign limit_hit   = err_count >= CNT_BITS'(ERR_LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_RAMP_UP;
            end
            S_RAMP_UP, S_HOLD, S_RAMP_DOWN: begin
                if (limit_hit)
                    state_next = S_FAULT;
                else if (!run)
                    state_next = (state == S_RAMP_DOWN && duty_now == '0) ? S_IDLE : S_RAMP_DOWN;
                else if (duty_now == goal)
                    state_next = S_HOLD;
                else
                    state_next = S_RAMP_UP;
            end
            S_FAULT: begin
                if (clear && !run) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        duty_next = duty_now;
        if (!active || state_next == S_FAULT)
            duty_next = '0;
        else if (step_wrap && duty_now < goal)
            duty_next = duty_now + PWM_BITS'(1);
        else if (step_wrap && duty_now > goal)
            duty_next = duty_now - PWM_BITS'(1);
    end

    // Settle window opens only on leaving IDLE; RAMP_DOWN -> RAMP_UP reuses whatever remains.
    always_comb begin
        settle_next = '0;
        if (state == S_IDLE && state_next == S_RAMP_UP)
            settle_next = SETTLE_BITS'(SETTLE_CYCLES);
        else if (settle_cnt != '0)
            settle_next = settle_cnt - SETTLE_BITS'(1);
    end

    assign err_clear_next = (state_next == S_IDLE) || (state_next == S_FAULT) ||
                            (settle_next != '0) || count_event;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt          <= '0;
            step_cnt         <= '0;
            settle_cnt       <= '0;
            duty_now         <= '0;
            state            <= S_IDLE;
            err_count        <= '0;
            err_prev         <= 1'b0;
            fault            <= 1'b0;
            heater_enable    <= 1'b0;
            heater_err_clear <= 1'b1;
        end else begin
            pwm_cnt          <= pwm_cnt + PWM_BITS'(1);
            step_cnt         <= (active && !step_wrap) ? step_cnt + STEP_BITS'(1) : '0;
            settle_cnt       <= settle_next;
            duty_now         <= duty_next;
            state            <= state_next;
            err_prev         <= heater_error;
            fault            <= (state_next == S_FAULT);
            heater_enable    <= active && (pwm_cnt < duty_now);
            heater_err_clear <= err_clear_next;
            if (clear)
                err_count <= '0;
            else if (count_event && err_count != '1)
                err_count <= err_count + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_heater_ctrl.sv
// Directed bench for heater_ctrl: ramp up/down, error counting into FAULT,
// fault exit and asynchronous reset, with hand-derived expected values.
module tb_heater_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [3:0]  target_duty;
    logic        clear;
    logic        heater_error;
    logic        heater_enable;
    logic        heater_err_clear;
    logic [3:0]  duty_now;
    logic [2:0]  state;
    logic [15:0] err_count;
    logic        fault;

    int assert_count;
    int fail_count;
    int en_count;

    heater_ctrl #(
        .PWM_BITS(4),
        .RAMP_DIV(4),
        .SETTLE_CYCLES(20),
        .ERR_LIMIT(2),
        .CNT_BITS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .target_duty(target_duty),
        .clear(clear),
        .heater_error(heater_error),
        .heater_enable(heater_enable),
        .heater_err_clear(heater_err_clear),
        .duty_now(duty_now),
        .state(state),
        .err_count(err_count),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] t, input logic c, input logic e);
        run          = r;
        target_duty  = t;
        clear        = c;
        heater_error = e;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 0);
        checkOutput({tag, "_duty"}, 32'(duty_now), 0);
        checkOutput({tag, "_enable"}, 32'(heater_enable), 0);
        checkOutput({tag, "_errclr"}, 32'(heater_err_clear), 1);
        checkOutput({tag, "_errcnt"}, 32'(err_count), 0);
        checkOutput({tag, "_fault"}, 32'(fault), 0);
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        $display("[TB] reset");
        tick(2);
        checkResetValues("reset");
        rst = 1'b0;
        tick(2);
        checkOutput("idle_state", 32'(state), 0);
        checkOutput("idle_errclr", 32'(heater_err_clear), 1);

        $display("[TB] ramp up to duty 8");
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        tick(1);
        checkOutput("up_e0_state", 32'(state), 1);
        checkOutput("up_e0_duty", 32'(duty_now), 0);
        checkOutput("up_e0_errclr", 32'(heater_err_clear), 1);
        tick(3);
        checkOutput("up_e3_duty", 32'(duty_now), 0);
        tick(1);
        checkOutput("up_e4_duty", 32'(duty_now), 1);
        tick(12);
        checkOutput("up_e16_duty", 32'(duty_now), 4);
        tick(3);
        checkOutput("settle_e19_errclr", 32'(heater_err_clear), 1);
        tick(1);
        checkOutput("settle_e20_errclr", 32'(heater_err_clear), 0);
        tick(11);
        checkOutput("up_e31_duty", 32'(duty_now), 7);
        tick(1);
        checkOutput("up_e32_duty", 32'(duty_now), 8);
        checkOutput("up_e32_state", 32'(state), 1);
        tick(1);
        checkOutput("hold_state", 32'(state), 2);
        en_count = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            en_count += int'(heater_enable);
        end
        checkOutput("hold_enable_per_16", 32'(en_count), 8);

        $display("[TB] ramp down");
        tick(3);
        applyStimulus(1'b0, 4'd8, 1'b0, 1'b0);
        tick(1);
        checkOutput("down_d0_state", 32'(state), 3);
        checkOutput("down_d0_duty", 32'(duty_now), 8);
        tick(30);
        checkOutput("down_d30_duty", 32'(duty_now), 1);
        tick(1);
        checkOutput("down_d31_duty", 32'(duty_now), 0);
        checkOutput("down_d31_state", 32'(state), 3);
        tick(1);
        checkOutput("down_idle_state", 32'(state), 0);
        en_count = 0;
        for (int i = 0; i < 8; i++) begin
            en_count += int'(heater_enable);
            tick(1);
        end
        checkOutput("idle_enable_count", 32'(en_count), 0);

        $display("[TB] errors into fault");
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        tick(41);
        checkOutput("err_pre_state", 32'(state), 2);
        checkOutput("err_pre_errclr", 32'(heater_err_clear), 0);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b1);
        tick(1);
        checkOutput("err1_count", 32'(err_count), 1);
        checkOutput("err1_errclr_pulse", 32'(heater_err_clear), 1);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        tick(1);
        checkOutput("err1_errclr_drop", 32'(heater_err_clear), 0);
        checkOutput("err1_state", 32'(state), 2);
        tick(2);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b1);
        tick(1);
        checkOutput("err2_count", 32'(err_count), 2);
        checkOutput("err2_errclr_pulse", 32'(heater_err_clear), 1);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        tick(1);
        checkOutput("fault_state", 32'(state), 4);
        checkOutput("fault_flag", 32'(fault), 1);
        checkOutput("fault_duty", 32'(duty_now), 0);
        tick(1);
        checkOutput("fault_enable", 32'(heater_enable), 0);
        checkOutput("fault_errclr", 32'(heater_err_clear), 1);

        $display("[TB] fault exit");
        applyStimulus(1'b1, 4'd8, 1'b1, 1'b0);
        tick(1);
        checkOutput("clr_run_count", 32'(err_count), 0);
        checkOutput("clr_run_state", 32'(state), 4);
        applyStimulus(1'b0, 4'd8, 1'b1, 1'b0);
        tick(1);
        checkOutput("clr_idle_state", 32'(state), 0);
        checkOutput("clr_idle_fault", 32'(fault), 0);
        applyStimulus(1'b0, 4'd8, 1'b0, 1'b0);

        $display("[TB] async reset mid-hold");
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        tick(41);
        checkOutput("pre_rst_state", 32'(state), 2);
        checkOutput("pre_rst_duty", 32'(duty_now), 8);
        #3;
        rst = 1'b1;
        #1;
        checkResetValues("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        checkOutput("restart_state", 32'(state), 1);
        checkOutput("restart_duty", 32'(duty_now), 0);
        tick(3);
        checkOutput("restart_e3_duty", 32'(duty_now), 0);
        tick(1);
        checkOutput("restart_e4_duty", 32'(duty_now), 1);
        tick(15);
        checkOutput("restart_e19_errclr", 32'(heater_err_clear), 1);
        tick(1);
        checkOutput("restart_e20_errclr", 32'(heater_err_clear), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
